rec_mc_seq: RTL and testbench
=============================

# rec_mc_seq

Per-LCU sequencer for the motion-compensation prediction transfer engine (`mc_tq`) in the `rec_mc` path. On one LCU start it runs up to three transfer passes: luma, then Cb, then Cr. For each pass it holds a stable component select and a latched partition word, issues a one-cycle start, and waits for the pass done. It then reports LCU completion, elapsed cycles, and sticky error flags to the reconstruction top.

## Interface
Parameters:
- `TIMEOUT`, default 4096, meaning: maximum cycles allowed in any single pass wait before abort.
- `CYC_W`, default 16, meaning: width of the LCU cycle counter.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  LCU start pulse. Accepted only in IDLE.
- `chroma_en_i`  in  1  run the Cb/Cr passes. Sampled with `start_i`.
- `partition_i`  in  42  LCU partition word. Sampled with `start_i`.
- `tq_start_o`  out  1  one-cycle start pulse to the transfer engine.
- `tq_sel_o`  out  2  component select: `TYPE_Y`, `TYPE_U` or `TYPE_V`.
- `tq_partition_o`  out  42  latched partition word, stable for the whole LCU.
- `tq_done_i`  in  1  transfer engine pass-done pulse.
- `done_o`  out  1  one-cycle LCU-complete pulse.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.
- `lcu_cyc_o`  out  CYC_W  cycles from start acceptance to `done_o` for the last LCU.
- `err_timeout_o`  out  1  sticky pass-timeout flag.
- `err_overrun_o`  out  1  sticky flag: `start_i` arrived while busy.

## Operation
FSM states and transitions:
- IDLE: on `start_i`, latch `partition_i` and `chroma_en_i`, clear both error flags, clear the cycle counter, go to Y_ISS.
- Y_ISS: `tq_start_o`=1, `tq_sel_o`=`TYPE_Y`, go to Y_WAIT.
- Y_WAIT: on `tq_done_i`, go to U_ISS if chroma is enabled, else to FIN.
- U_ISS: go to U_WAIT.
- U_WAIT: on `tq_done_i`, go to V_ISS.
- V_ISS: go to V_WAIT.
- V_WAIT: on `tq_done_i`, go to FIN.
- FIN: `done_o`=1, update `lcu_cyc_o`, go to IDLE.

Select and partition rules:
- `tq_sel_o` is registered. It changes only on entry to an ISS state and holds through the matching WAIT state; the transfer engine uses the select combinationally for the whole pass.
- `tq_sel_o` in IDLE and FIN keeps the last value driven.
- `tq_partition_o` changes only when a start is accepted.

Watchdog:
- A wait counter clears on entry to each WAIT state and increments every WAIT cycle.
- Reaching `TIMEOUT`-1 without `tq_done_i` sets `err_timeout_o` and goes to FIN. `done_o` still pulses, so the top never hangs.

Cycle counter:
- Increments every non-IDLE cycle and saturates at all-ones.
- `lcu_cyc_o` is loaded in FIN with the count including the FIN cycle.

Boundary conditions:
- `tq_done_i` outside a WAIT state is ignored.
- `tq_done_i` in the same cycle as timeout expiry: the done wins, no error is set, and the normal transition is taken.
- `start_i` while busy: the start is ignored and `err_overrun_o` is set.
- `start_i` in the FIN cycle counts as busy.
- Reset mid-LCU returns to IDLE immediately with all outputs at their reset values. No `done_o` is issued.

Reset values:
- 0 for `tq_start_o`, `done_o`, `busy_o`, `lcu_cyc_o`, `err_timeout_o`, `err_overrun_o` and `tq_partition_o`.
- `tq_sel_o` resets to `TYPE_Y`.

## Timing
- `start_i` accepted at cycle 0 → `tq_start_o` and `busy_o` high at cycle 1.
- `tq_done_i` at cycle n → next pass `tq_start_o` at n+1, or `done_o` at n+1 after the last pass.
- `done_o` and `busy_o` are both high in the FIN cycle. `busy_o` is low at FIN+1, and a new start is accepted from that cycle.
- Minimum LCU turnaround, luma-only, with `tq_done_i` returned one cycle after start: 4 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Component encodings (`TYPE_Y`=2'b00, `TYPE_U`=2'b10, `TYPE_V`=2'b11) and the `PART_*` encodings come from the shared `enc_defines.v`.
- FSM state encoding is local to the module.
- The saturating counter is written inline. No sub-module is needed.
- `rec_mc_seq` instantiates nothing. The rec top wires it directly to `mc_tq` `start_i`, `sel_i`, `partition_i` and `done_o`.

## Test plan
- Luma-only: `start_i`, `chroma_en_i`=0, partition 42'h0, `tq_done_i` 10 cycles after each start → one `tq_start_o` with sel 00, `done_o` at cycle 12, `lcu_cyc_o`=12.
- Full 4:2:0: `chroma_en_i`=1 → three `tq_start_o` pulses with sel 00, 10, 11 in order. Sel is stable between each start and its done, and `done_o` pulses exactly once.
- Partition latch: change `partition_i` after the start is accepted → `tq_partition_o` keeps the latched value until the next accepted start.
- Timeout: `TIMEOUT`=16, never return `tq_done_i` on the U pass → `err_timeout_o`=1, `done_o` pulses, V pass skipped. The flag clears on the next start.
- Overrun and stray done: `start_i` during Y_WAIT and `tq_done_i` in IDLE → `err_overrun_o`=1, no state change, no extra `tq_start_o`.
- Reset mid-U_WAIT → all outputs at reset values next cycle, no `done_o`. A following start runs normally.

Source files
------------

// File: rtl/rec_mc_seq_pkg.sv
// Shared encodings for the rec_mc per-LCU transfer sequencer.
package rec_mc_seq_pkg;

  // Component select encodings seen by the mc_tq transfer engine.
  localparam logic [1:0] TYPE_Y = 2'b00;
  localparam logic [1:0] TYPE_U = 2'b10;
  localparam logic [1:0] TYPE_V = 2'b11;

  // LCU partition word width.
  localparam int PART_W = 42;

  // Sequencer states: one issue/wait pair per component, then a finish cycle.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_Y_ISS  = 3'd1,
    ST_Y_WAIT = 3'd2,
    ST_U_ISS  = 3'd3,
    ST_U_WAIT = 3'd4,
    ST_V_ISS  = 3'd5,
    ST_V_WAIT = 3'd6,
    ST_FIN    = 3'd7
  } state_t;

endpackage

// File: rtl/rec_mc_seq.sv
// Per-LCU sequencer for the mc_tq transfer engine: runs the luma pass and,
// when enabled, the Cb and Cr passes, then reports completion, elapsed
// cycles and sticky error flags.
//
// Handshake: tq_start_o is a one-cycle request pulse and tq_done_i a
// one-cycle completion pulse; there is no valid/ready back-pressure. A done
// pulse is only meaningful in a WAIT state and is dropped anywhere else.
// start_i is likewise a pulse, taken only in IDLE; a start seen in any other
// state (FIN included) is discarded and flagged on err_overrun_o.
module rec_mc_seq
  import rec_mc_seq_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CYC_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              chroma_en_i,
  input  logic [PART_W-1:0] partition_i,
  output logic              tq_start_o,
  output logic [1:0]        tq_sel_o,
  output logic [PART_W-1:0] tq_partition_o,
  input  logic              tq_done_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [CYC_W-1:0]  lcu_cyc_o,
  output logic              err_timeout_o,
  output logic              err_overrun_o,
  output logic [2:0]        state_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

  state_t              state;
  logic                chroma_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [CYC_W-1:0]    cyc_inc;
  logic [WAIT_W-1:0]   wait_inc;
  logic                wait_expired;

  assign state_o = state;

  // Saturating cycle increment, wait increment and watchdog expiry.
  always_comb begin
    cyc_inc      = (cyc_cnt == CYC_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
    wait_inc     = wait_cnt + 1'b1;
    wait_expired = (wait_cnt == WAIT_LAST);
  end

  // Sequencer FSM with registered outputs, watchdog and LCU cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      chroma_q       <= 1'b0;
      wait_cnt       <= '0;
      cyc_cnt        <= '0;
      tq_start_o     <= 1'b0;
      tq_sel_o       <= TYPE_Y;
      tq_partition_o <= '0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
      lcu_cyc_o      <= '0;
      err_timeout_o  <= 1'b0;
      err_overrun_o  <= 1'b0;
    end else begin
      tq_start_o <= 1'b0;
      done_o     <= 1'b0;

      if (state != ST_IDLE) begin
        cyc_cnt <= cyc_inc;
        if (start_i) begin
          err_overrun_o <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            tq_partition_o <= partition_i;
            chroma_q       <= chroma_en_i;
            err_timeout_o  <= 1'b0;
            err_overrun_o  <= 1'b0;
            cyc_cnt        <= '0;
            tq_start_o     <= 1'b1;
            tq_sel_o       <= TYPE_Y;
            busy_o         <= 1'b1;
            state          <= ST_Y_ISS;
          end
        end

        ST_Y_ISS: begin
          wait_cnt <= '0;
          state    <= ST_Y_WAIT;
        end

        ST_Y_WAIT: begin
          if (tq_done_i) begin
            if (chroma_q) begin
              tq_start_o <= 1'b1;
              tq_sel_o   <= TYPE_U;
              state      <= ST_U_ISS;
            end else begin
              done_o <= 1'b1;
              state  <= ST_FIN;
            end
          end else if (wait_expired) begin
            err_timeout_o <= 1'b1;
            done_o        <= 1'b1;
            state         <= ST_FIN;
          end else begin
            wait_cnt <= wait_inc;
          end
        end

        ST_U_ISS: begin
          wait_cnt <= '0;
          state    <= ST_U_WAIT;
        end

        ST_U_WAIT: begin
          if (tq_done_i) begin
            tq_start_o <= 1'b1;
            tq_sel_o   <= TYPE_V;
            state      <= ST_V_ISS;
          end else if (wait_expired) begin
            err_timeout_o <= 1'b1;
            done_o        <= 1'b1;
            state         <= ST_FIN;
          end else begin
            wait_cnt <= wait_inc;
          end
        end

        ST_V_ISS: begin
          wait_cnt <= '0;
          state    <= ST_V_WAIT;
        end

        ST_V_WAIT: begin
          if (tq_done_i) begin
            done_o <= 1'b1;
            state  <= ST_FIN;
          end else if (wait_expired) begin
            err_timeout_o <= 1'b1;
            done_o        <= 1'b1;
            state         <= ST_FIN;
          end else begin
            wait_cnt <= wait_inc;
          end
        end

        ST_FIN: begin
          // Count reported to the top includes this FIN cycle.
          lcu_cyc_o <= cyc_inc;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rec_mc_seq.sv
// Bench for rec_mc_seq: directed scenarios plus randomized LCUs, checked
// against a pass-level model of sequencing, latency and error flags.
module tb_rec_mc_seq;
  import rec_mc_seq_pkg::*;

  localparam int TO    = 16;
  localparam int CYC_W = 16;

  logic              clk;
  logic              rstn;
  logic              start_i;
  logic              chroma_en_i;
  logic [PART_W-1:0] partition_i;
  logic              tq_start_o;
  logic [1:0]        tq_sel_o;
  logic [PART_W-1:0] tq_partition_o;
  logic              tq_done_i;
  logic              done_o;
  logic              busy_o;
  logic [CYC_W-1:0]  lcu_cyc_o;
  logic              err_timeout_o;
  logic              err_overrun_o;
  logic [2:0]        state_dbg;

  logic [1:0] exp_q[$];
  logic [1:0] pass_sel[3];
  int n_checks;
  int n_pass;

  rec_mc_seq #(.TIMEOUT(TO), .CYC_W(CYC_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .chroma_en_i    (chroma_en_i),
    .partition_i    (partition_i),
    .tq_start_o     (tq_start_o),
    .tq_sel_o       (tq_sel_o),
    .tq_partition_o (tq_partition_o),
    .tq_done_i      (tq_done_i),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .lcu_cyc_o      (lcu_cyc_o),
    .err_timeout_o  (err_timeout_o),
    .err_overrun_o  (err_overrun_o),
    .state_o        (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every transfer start must match the next expected select.
  always @(negedge clk) begin
    if (rstn && tq_start_o) begin
      check("start_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("start_sel", 64'(tq_sel_o), 64'(exp_q.pop_front()));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_tq_start"}, 64'(tq_start_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_lcu_cyc"}, 64'(lcu_cyc_o), 64'd0);
    check({tag, "_err_to"}, 64'(err_timeout_o), 64'd0);
    check({tag, "_err_ov"}, 64'(err_overrun_o), 64'd0);
    check({tag, "_part"}, 64'(tq_partition_o), 64'd0);
    check({tag, "_sel"}, 64'(tq_sel_o), 64'(TYPE_Y));
  endtask

  // Idle cycles, optionally with stray done pulses that must be ignored.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      check("idle_busy", 64'(busy_o), 64'd0);
      check("idle_tq_start", 64'(tq_start_o), 64'd0);
      check("idle_done", 64'(done_o), 64'd0);
      tq_done_i = stray && (i < n - 1) && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      tq_done_i = 1'b0;
    end
  endtask

  // Driver + model for one LCU. d[p] is the wait-cycle index at which the
  // pass done is returned (>= TO means never). ov_pass/ov_k inject a start
  // during a wait; fin_ov injects one in the FIN cycle; rst_pass resets the
  // DUT in the third wait cycle of that pass.
  task automatic run_lcu(input bit chroma, input logic [PART_W-1:0] part,
                         input int d0, input int d1, input int d2,
                         input int ov_pass, input int ov_k,
                         input bit fin_ov, input int rst_pass);
    int d[3];
    int npass;
    int exp_cyc;
    bit exp_to;
    bit exp_ov;
    logic [1:0] last_sel;
    d[0] = d0; d[1] = d1; d[2] = d2;
    npass = chroma ? 3 : 1;
    exp_cyc = 0;
    exp_to = 1'b0;
    exp_ov = 1'b0;
    last_sel = TYPE_Y;

    start_i = 1'b1;
    chroma_en_i = chroma;
    partition_i = part;
    @(posedge clk); #1;
    start_i = 1'b0;
    chroma_en_i = ~chroma;
    partition_i = {$urandom, $urandom};

    for (int p = 0; p < npass; p++) begin
      exp_q.push_back(pass_sel[p]);
      check("iss_tq_start", 64'(tq_start_o), 64'd1);
      check("iss_sel", 64'(tq_sel_o), 64'(pass_sel[p]));
      check("iss_busy", 64'(busy_o), 64'd1);
      if (p == 0) begin
        check("start_err_to_clr", 64'(err_timeout_o), 64'd0);
        check("start_err_ov_clr", 64'(err_overrun_o), 64'd0);
        check("part_latch", 64'(tq_partition_o), 64'(part));
      end
      last_sel = pass_sel[p];
      exp_cyc += 1;
      @(posedge clk); #1;
      for (int k = 0; k < TO; k++) begin
        if (p == rst_pass && k == 2) begin
          rstn = 1'b0;
          #1;
          check_reset_vals("rst_mid");
          #1;
          rstn = 1'b1;
          @(posedge clk); #1;
          check("rst_no_done", 64'(done_o), 64'd0);
          check("rst_idle", 64'(busy_o), 64'd0);
          check("rst_q_empty", 64'(exp_q.size()), 64'd0);
          return;
        end
        tq_done_i = (k == d[p]);
        start_i = (p == ov_pass && k == ov_k);
        if (start_i) exp_ov = 1'b1;
        check("wait_sel", 64'(tq_sel_o), 64'(pass_sel[p]));
        check("wait_tq_start", 64'(tq_start_o), 64'd0);
        check("wait_done", 64'(done_o), 64'd0);
        check("wait_part", 64'(tq_partition_o), 64'(part));
        exp_cyc += 1;
        @(posedge clk); #1;
        tq_done_i = 1'b0;
        start_i = 1'b0;
        if (k == d[p]) break;
      end
      if (d[p] >= TO) begin
        exp_to = 1'b1;
        break;
      end
    end

    check("fin_done", 64'(done_o), 64'd1);
    check("fin_busy", 64'(busy_o), 64'd1);
    check("fin_tq_start", 64'(tq_start_o), 64'd0);
    check("fin_err_to", 64'(err_timeout_o), 64'(exp_to));
    exp_cyc += 1;
    start_i = fin_ov;
    if (fin_ov) exp_ov = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("post_done", 64'(done_o), 64'd0);
    check("post_busy", 64'(busy_o), 64'd0);
    check("post_tq_start", 64'(tq_start_o), 64'd0);
    check("lcu_cyc", 64'(lcu_cyc_o), 64'(exp_cyc));
    check("post_err_to", 64'(err_timeout_o), 64'(exp_to));
    check("post_err_ov", 64'(err_overrun_o), 64'(exp_ov));
    check("post_part", 64'(tq_partition_o), 64'(part));
    check("post_sel", 64'(tq_sel_o), 64'(last_sel));
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 6);
    if (r < 8) return $urandom_range(7, TO - 1);
    if (r == 8) return TO - 1;
    return TO + 5;
  endfunction

  initial begin
    n_checks = 0;
    n_pass = 0;
    pass_sel[0] = TYPE_Y;
    pass_sel[1] = TYPE_U;
    pass_sel[2] = TYPE_V;
    rstn = 1'b0;
    start_i = 1'b0;
    chroma_en_i = 1'b0;
    partition_i = '0;
    tq_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Luma-only, done 10 cycles after the start pulse: lcu_cyc = 12.
    run_lcu(1'b0, '0, 9, 0, 0, -1, 0, 1'b0, -1);
    idle_cycles(3, 1'b1);
    // Full 4:2:0.
    run_lcu(1'b1, 42'h2AB_CDEF_0123, 3, 5, 2, -1, 0, 1'b0, -1);
    idle_cycles(1, 1'b0);
    // Timeout on the U pass; V skipped.
    run_lcu(1'b1, 42'h155_5555_5555, 2, TO + 5, 0, -1, 0, 1'b0, -1);
    // Flags clear on next start; minimum turnaround back-to-back.
    run_lcu(1'b0, 42'h3FF_FFFF_FFFF, 0, 0, 0, -1, 0, 1'b0, -1);
    run_lcu(1'b0, 42'h000_0000_0001, 0, 0, 0, -1, 0, 1'b0, -1);
    // Overrun during Y_WAIT, then stray dones in IDLE.
    run_lcu(1'b0, 42'h123_4567_89AB, 4, 0, 0, 0, 1, 1'b0, -1);
    idle_cycles(4, 1'b1);
    // Done coinciding with watchdog expiry wins.
    run_lcu(1'b1, 42'h0F0_F0F0_F0F0, TO - 1, 1, TO - 1, -1, 0, 1'b0, -1);
    // Start in FIN counts as overrun.
    run_lcu(1'b0, 42'h0AA_AAAA_AAAA, 2, 0, 0, -1, 0, 1'b1, -1);
    idle_cycles(1, 1'b0);
    // Reset mid-U_WAIT, then a normal LCU.
    run_lcu(1'b1, 42'h1C3_3C3C_3C3C, 1, 6, 0, -1, 0, 1'b0, 1);
    idle_cycles(2, 1'b0);
    run_lcu(1'b1, 42'h222_3333_4444, 2, 2, 2, -1, 0, 1'b0, -1);

    // Randomized LCUs.
    for (int n = 0; n < 40; n++) begin
      run_lcu(1'($urandom_range(0, 1)), {$urandom, $urandom},
              rand_delay(), rand_delay(), rand_delay(),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
              $urandom_range(0, 4), 1'($urandom_range(0, 5) == 0), -1);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), 1'b1);
    end

    check("q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
